spi_pos_master: RTL
===================

// Module: spi_pos_master
// PURPOSE
//  SPI master that reads the three 32-bit encoder position counters from the encoder board's SPI slave.
//  It is the other end of the same link, so it replaces the external mbed master in
//  board-to-board and loopback test setups. A start pulse produces one 96-bit read frame.
//  The received frame is split into three position registers, and completion is flagged by a done pulse.
// PARAMETERS
//  CLK_DIV    4   osc cycles per SCK half-period; legal range 4..255 (the slave's 3-stage synchronisers need >=4)
//  FRAME_BITS 96  bits per frame; fixed at 3x32, other values unsupported
//  SETUP_CYC  8   osc cycles from SSEL falling to the first SCK rising edge (slave latches counters here)
//  GAP_CYC    8   minimum osc cycles SSEL stays high after a frame before the next frame may start
// PORTS
//  osc        in   1   system clock; all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  start      in   1   1-cycle request to read one frame; ignored while busy=1
//  busy       out  1   high from the cycle after an accepted start until done
//  done       out  1   1-cycle pulse; position outputs are valid and updated in the same cycle
//  SCK        out  1   SPI clock, idle low
//  SSEL       out  1   slave select, active low, idle high
//  MOSI       out  1   held 0 (link is read-only)
//  MISO       in   1   serial data from the slave, MSB first
//  position   out  32  frame bits [95:64] (encoder 1)
//  position2  out  32  frame bits [63:32] (encoder 2)
//  position3  out  32  frame bits [31:0]  (encoder 3)
//  frame_cnt  out  16  count of completed frames; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset values: SCK=0, SSEL=1, MOSI=0, busy=0, done=0, position/2/3=0, frame_cnt=0, state=IDLE.
//  - All outputs are registered. MISO passes through a 2-flop synchroniser before it is sampled.
//  - FSM states and transitions:
//      IDLE  -> SETUP on start. SSEL=0 in the next cycle; busy=1.
//      SETUP -> HI after SETUP_CYC cycles.
//      HI    (SCK=1, CLK_DIV cycles) -> LO.
//      LO    (SCK=0, CLK_DIV cycles) -> HI, or -> HOLD once bit_cnt reaches 96.
//      HOLD  (CLK_DIV cycles, SCK=0, SSEL=0) -> GAP. SSEL=1 on entry to GAP.
//      GAP   (GAP_CYC cycles) -> IDLE. done pulses on the final GAP cycle; busy drops in the same cycle.
//  - Sampling: the synchronised MISO is sampled on the last cycle of each LO phase.
//    It is shifted into rx[0] with rx<=rx<<1, so the first bit sampled ends up in rx[95].
//  - bit_cnt is 7 bits. It is cleared in SETUP and incremented per sample; exactly 96 samples per frame.
//  - position/2/3 load from rx only in the done cycle; they hold between frames.
//  - frame_cnt increments in the done cycle.
//  - Frame length in osc cycles = 1 + SETUP_CYC + 96*2*CLK_DIV + CLK_DIV + GAP_CYC (start to done inclusive).
//  - A start in the same cycle as done is ignored. A start in the cycle after done is accepted.
//  - A start while busy is dropped (not queued).
//  - rst mid-frame: the next edge forces SSEL=1 and SCK=0, with no done pulse.
//    The partial rx is discarded, position outputs go to 0, and the FSM returns to IDLE.
//  - SCK never glitches: every HI and LO phase lasts exactly CLK_DIV cycles.
//  - There are no SCK edges while SSEL=1.
// TESTING
//  1. Bench slave model returns 0x00000001_FFFFFFFF_80000000; one start ->
//     position=0x00000001, position2=0xFFFFFFFF, position3=0x80000000, frame_cnt=1.
//  2. CLK_DIV=4: count cycles start->done = 1+8+768+4+8 = 789.
//     Exactly 96 SCK rising edges; SSEL low for 8+768+4 = 780 cycles.
//  3. Pulse start at cycles 10, 20, and 300 within one frame -> one frame only.
//     Start in the done cycle is ignored; start one cycle later -> a second frame runs, frame_cnt=2.
//  4. Assert rst for 1 cycle at bit 40 -> SSEL=1 and SCK=0 the next cycle, no done, position=0.
//     A following start reads the full frame correctly.
//  5. Loopback with three qdec instances in the top level: drive encoder 1 +1000 counts, encoder 2 -5
//     (0xFFFFFFFB), encoder 3 0 -> after one frame, position=1000, position2=0xFFFFFFFB, position3=0.
//  6. Preload frame_cnt to 0xFFFF via forced frames (or a bench force), run one frame -> frame_cnt=0.

Source files
------------

// File: rtl/spi_pos_master.sv
// SPI read master for the encoder board: one start pulse clocks in a 96-bit frame and splits it
// into three 32-bit position registers, flagged by a one-cycle done pulse.
`timescale 1ns / 1ps

module spi_pos_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FRAME_BITS = 96,
    parameter int unsigned SETUP_CYC  = 8,
    parameter int unsigned GAP_CYC    = 8
) (
    input  logic        osc,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        SCK,
    output logic        SSEL,
    output logic        MOSI,
    input  logic        MISO,
    output logic [31:0] position,
    output logic [31:0] position2,
    output logic [31:0] position3,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {StIdle, StSetup, StHi, StLo, StHold, StGap} state_e;

    localparam logic [7:0] DivLast   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SetupLast = 8'(SETUP_CYC - 1);
    localparam logic [7:0] GapLast   = 8'(GAP_CYC - 1);
    localparam logic [6:0] BitLast   = 7'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [6:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   rx_q, rx_d;
    logic [1:0]              miso_sync_q;
    logic                    done_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 8'd1;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) state_d = StSetup;
            end
            StSetup: begin
                bit_cnt_d = '0;
                if (cnt_q == SetupLast) begin
                    state_d = StHi;
                    cnt_d   = '0;
                end
            end
            StHi: begin
                if (cnt_q == DivLast) begin
                    state_d = StLo;
                    cnt_d   = '0;
                end
            end
            StLo: begin
                // Sample just before the next rising edge, long after the slave's data settled.
                if (cnt_q == DivLast) begin
                    rx_d      = {rx_q[FRAME_BITS-2:0], miso_sync_q[1]};
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    cnt_d     = '0;
                    state_d   = (bit_cnt_q == BitLast) ? StHold : StHi;
                end
            end
            StHold: begin
                if (cnt_q == DivLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        done_d = (state_d == StGap) && (cnt_d == GapLast);
    end

    // Outputs are registered from the next-state decode so they line up with the state itself.
    always_ff @(posedge osc) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            miso_sync_q <= '0;
            SCK         <= 1'b0;
            SSEL        <= 1'b1;
            MOSI        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            position    <= '0;
            position2   <= '0;
            position3   <= '0;
            frame_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            miso_sync_q <= {miso_sync_q[0], MISO};
            SCK         <= (state_d == StHi);
            SSEL        <= (state_d == StIdle) || (state_d == StGap);
            MOSI        <= 1'b0;
            busy        <= (state_d != StIdle) && !done_d;
            done        <= done_d;
            if (done_d) begin
                position  <= rx_d[95:64];
                position2 <= rx_d[63:32];
                position3 <= rx_d[31:0];
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
